// File: rtl/ycrcb_pkg.sv
// Shared definitions for the BT.656 4:2:2 unpacker and related sync blocks.
//   - Timing reference code words and the chroma offset
//   - Positions of the F/V/H flags and protection bits within the XYZ word
//   - Capture state enumeration
//   - Helper that converts offset-binary chroma to two's-complement
package ycrcb_pkg;

    localparam logic [9:0] TRS_FF        = 10'h3FF;
    localparam logic [9:0] TRS_00        = 10'h000;
    localparam logic [9:0] CHROMA_OFFSET = 10'd512;

    // Bit positions inside the XYZ word
    localparam int unsigned XYZ_ONE   = 9;
    localparam int unsigned XYZ_F     = 8;
    localparam int unsigned XYZ_V     = 7;
    localparam int unsigned XYZ_H     = 6;
    localparam int unsigned XYZ_P_MSB = 5;
    localparam int unsigned XYZ_P_LSB = 2;

    typedef enum logic [2:0] {
        StHunt,
        StP1,
        StP2,
        StP3,
        StACb,
        StAY0,
        StACr,
        StAY1
    } unpack_state_e;

    // Subtracting 512 modulo 1024 is the same as flipping the MSB.
    function automatic logic [9:0] chroma_to_signed(input logic [9:0] d);
        return d - CHROMA_OFFSET;
    endfunction

endpackage

// File: rtl/trs_decode.sv
// Combinational decoder for the XYZ word of a BT.656 timing reference code.
// Ports:
//   din_i        - candidate XYZ word
//   check_prot_i - 1: require protection bits to match F/V/H; 0: ignore them
//   f_o, v_o, h_o - field, vertical blanking and EAV/SAV flags
//   ok_o         - word is a valid XYZ (bit 9 set, protection good if checked)
module trs_decode
    import ycrcb_pkg::*;
(
    input  logic [9:0] din_i,
    input  logic       check_prot_i,
    output logic       f_o,
    output logic       v_o,
    output logic       h_o,
    output logic       ok_o
);

    logic       f;
    logic       v;
    logic       h;
    logic [3:0] prot_exp;

    always_comb begin
        f        = din_i[XYZ_F];
        v        = din_i[XYZ_V];
        h        = din_i[XYZ_H];
        prot_exp = {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
        ok_o     = din_i[XYZ_ONE] &&
                   (!check_prot_i || (din_i[XYZ_P_MSB:XYZ_P_LSB] == prot_exp));
        f_o      = f;
        v_o      = v;
        h_o      = h;
    end

endmodule

// File: rtl/ycrcb422_unpack.sv
// BT.656 4:2:2 to per-pixel 4:4:4 unpacker.
// Hunts for 3FF/000/000/XYZ timing references, tracks F and V, and after an
// active-line SAV demultiplexes Cb/Y0/Cr/Y1 into two pixels sharing chroma.
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   din, din_en  - sample word and its qualifier
//   y, cr, cb    - registered luma and signed chroma (held between strobes)
//   pix_valid    - one-cycle strobe for y/cr/cb/pix_x
//   pix_x        - pixel index within the line
//   field/vblank - F/V from the last accepted XYZ
//   line_start   - pulse after an accepted active-line SAV
//   sync_err     - pulse after an XYZ that failed bit-9 or protection checks
module ycrcb422_unpack
    import ycrcb_pkg::*;
#(
    parameter int unsigned LINE_PIXELS = 720,
    parameter bit          CHECK_PROT  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] din,
    input  logic       din_en,
    output logic [9:0] y,
    output logic [9:0] cr,
    output logic [9:0] cb,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic       field,
    output logic       vblank,
    output logic       line_start,
    output logic       sync_err
);

    localparam logic [9:0] LastPix = 10'(LINE_PIXELS - 1);

    unpack_state_e state_q, state_d;
    logic [9:0]    cb_hold_q, cb_hold_d;
    logic [9:0]    y0_q, y0_d;
    logic [9:0]    cnt_q, cnt_d;
    logic [9:0]    y_q, y_d;
    logic [9:0]    cr_q, cr_d;
    logic [9:0]    cb_q, cb_d;
    logic [9:0]    pix_x_q, pix_x_d;
    logic          pix_valid_q, pix_valid_d;
    logic          field_q, field_d;
    logic          vblank_q, vblank_d;
    logic          line_start_q, line_start_d;
    logic          sync_err_q, sync_err_d;

    logic trs_f;
    logic trs_v;
    logic trs_h;
    logic trs_ok;

    trs_decode u_trs_decode (
        .din_i        (din),
        .check_prot_i (CHECK_PROT),
        .f_o          (trs_f),
        .v_o          (trs_v),
        .h_o          (trs_h),
        .ok_o         (trs_ok)
    );

    always_comb begin
        state_d      = state_q;
        cb_hold_d    = cb_hold_q;
        y0_d         = y0_q;
        cnt_d        = cnt_q;
        y_d          = y_q;
        cr_d         = cr_q;
        cb_d         = cb_q;
        pix_x_d      = pix_x_q;
        field_d      = field_q;
        vblank_d     = vblank_q;
        pix_valid_d  = 1'b0;
        line_start_d = 1'b0;
        sync_err_d   = 1'b0;

        if (din_en) begin
            if (din == TRS_FF) begin
                // A new preamble always wins; any half-collected pair is dropped.
                state_d = StP1;
            end else begin
                case (state_q)
                    StHunt: state_d = StHunt;
                    StP1:   state_d = (din == TRS_00) ? StP2 : StHunt;
                    StP2:   state_d = (din == TRS_00) ? StP3 : StHunt;
                    StP3: begin
                        state_d = StHunt;
                        if (!trs_ok) begin
                            sync_err_d = 1'b1;
                        end else begin
                            field_d  = trs_f;
                            vblank_d = trs_v;
                            if (!trs_h && !trs_v) begin
                                state_d      = StACb;
                                cnt_d        = '0;
                                line_start_d = 1'b1;
                            end
                        end
                    end
                    StACb: begin
                        cb_hold_d = chroma_to_signed(din);
                        state_d   = StAY0;
                    end
                    StAY0: begin
                        y0_d    = din;
                        state_d = StACr;
                    end
                    StACr: begin
                        y_d         = y0_q;
                        cb_d        = cb_hold_q;
                        cr_d        = chroma_to_signed(din);
                        pix_x_d     = cnt_q;
                        pix_valid_d = 1'b1;
                        cnt_d       = cnt_q + 10'd1;
                        state_d     = (cnt_q == LastPix) ? StHunt : StAY1;
                    end
                    StAY1: begin
                        // Chroma outputs still hold this pair's Cb/Cr.
                        y_d         = din;
                        pix_x_d     = cnt_q;
                        pix_valid_d = 1'b1;
                        cnt_d       = cnt_q + 10'd1;
                        state_d     = (cnt_q == LastPix) ? StHunt : StACb;
                    end
                    default: state_d = StHunt;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StHunt;
            cb_hold_q    <= '0;
            y0_q         <= '0;
            cnt_q        <= '0;
            y_q          <= '0;
            cr_q         <= '0;
            cb_q         <= '0;
            pix_x_q      <= '0;
            pix_valid_q  <= 1'b0;
            field_q      <= 1'b0;
            vblank_q     <= 1'b0;
            line_start_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cb_hold_q    <= cb_hold_d;
            y0_q         <= y0_d;
            cnt_q        <= cnt_d;
            y_q          <= y_d;
            cr_q         <= cr_d;
            cb_q         <= cb_d;
            pix_x_q      <= pix_x_d;
            pix_valid_q  <= pix_valid_d;
            field_q      <= field_d;
            vblank_q     <= vblank_d;
            line_start_q <= line_start_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign y          = y_q;
    assign cr         = cr_q;
    assign cb         = cb_q;
    assign pix_x      = pix_x_q;
    assign pix_valid  = pix_valid_q;
    assign field      = field_q;
    assign vblank     = vblank_q;
    assign line_start = line_start_q;
    assign sync_err   = sync_err_q;

endmodule
